// File: rtl/fp32_div_seq_ctrl.sv
// fp32_div_seq_ctrl
//   Sequencing and exception wrapper around an FP32 SRT radix-4 divider core.
//   An operand pair is taken over valid/ready and classified. Special operands
//   (NaN, inf, zero, denormal) are answered directly. Normal operands restart
//   the core and wait for its iteration flag. The result is then held under
//   downstream backpressure.
// Ports
//   clk_i              clock, rising edge
//   rst_i              asynchronous reset, active low
//   in_valid_i/ready_o operand handshake; in_dividend_i, in_divisor_i operands
//   core_dividend_o    latched operands driven to the core
//   core_divisor_o
//   core_rst_o         registered active-low reset/start to the core
//   core_quotient_i    core result
//   core_flag_i        core iteration counter
//   out_valid_o/ready_i result handshake
//   out_result_o       quotient
//   out_flags_o        {invalid, divzero, overflow, underflow}
module fp32_div_seq_ctrl #(
  parameter int          CORE_ITERS = 15,
  parameter logic [31:0] QNAN       = 32'h7FC0_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_dividend_i,
  input  logic [31:0] in_divisor_i,
  output logic [31:0] core_dividend_o,
  output logic [31:0] core_divisor_o,
  output logic        core_rst_o,
  input  logic [31:0] core_quotient_i,
  input  logic [5:0]  core_flag_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_result_o,
  output logic [3:0]  out_flags_o
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  localparam logic [5:0] FLAG_DONE = 6'(CORE_ITERS);
  localparam logic [5:0] WD_LIM    = 6'(CORE_ITERS + 4);

  state_e      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_result_q, out_result_d;
  logic [3:0]  out_flags_q, out_flags_d;
  logic        core_rst_q, core_rst_d;
  logic [31:0] dvd_q, dvd_d, dvs_q, dvs_d;
  logic [5:0]  wd_q, wd_d;

  // Classification of the latched operands (evaluated in LOAD).
  logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special, r_sign;
  logic [31:0] spec_result;
  logic [3:0]  spec_flags;

  always_comb begin
    a_nan  = (dvd_q[30:23] == 8'hFF) && (dvd_q[22:0] != '0);
    b_nan  = (dvs_q[30:23] == 8'hFF) && (dvs_q[22:0] != '0);
    a_inf  = (dvd_q[30:23] == 8'hFF) && (dvd_q[22:0] == '0);
    b_inf  = (dvs_q[30:23] == 8'hFF) && (dvs_q[22:0] == '0);
    // Exponent 0 covers denormals, which flush to zero.
    a_zero = (dvd_q[30:23] == 8'h00);
    b_zero = (dvs_q[30:23] == 8'h00);
    r_sign = dvd_q[31] ^ dvs_q[31];
    special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

    spec_result = {r_sign, 31'h0};
    spec_flags  = 4'b0000;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_result = QNAN;
      spec_flags  = 4'b1000;
    end else if (b_zero) begin
      spec_result = {r_sign, 8'hFF, 23'h0};
      spec_flags  = 4'b0100;
    end else if (a_inf) begin
      spec_result = {r_sign, 8'hFF, 23'h0};
    end
  end

  always_comb begin
    state_d      = state_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    core_rst_d   = 1'b1;
    dvd_d        = dvd_q;
    dvs_d        = dvs_q;
    wd_d         = wd_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i && in_ready_q) begin
          dvd_d      = in_dividend_i;
          dvs_d      = in_divisor_i;
          in_ready_d = 1'b0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (special) begin
          out_result_d = spec_result;
          out_flags_d  = spec_flags;
          out_valid_d  = 1'b1;
          state_d      = DONE;
        end else begin
          core_rst_d = 1'b0;
          wd_d       = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        wd_d = wd_q + 6'd1;
        // While core_rst_q is still low the core has not seen the restart,
        // so its flag still reflects the previous free-running value.
        if (core_rst_q && core_flag_i == FLAG_DONE) begin
          out_result_d = core_quotient_i;
          out_flags_d  = {2'b00, core_quotient_i[30:23] == 8'hFF,
                          core_quotient_i[30:23] == 8'h00};
          out_valid_d  = 1'b1;
          state_d      = DONE;
        end else if (wd_q == WD_LIM) begin
          out_result_d = QNAN;
          out_flags_d  = 4'b1000;
          out_valid_d  = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
      core_rst_q   <= 1'b0;
      dvd_q        <= '0;
      dvs_q        <= '0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
      core_rst_q   <= core_rst_d;
      dvd_q        <= dvd_d;
      dvs_q        <= dvs_d;
      wd_q         <= wd_d;
    end
  end

  assign in_ready_o      = in_ready_q;
  assign out_valid_o     = out_valid_q;
  assign out_result_o    = out_result_q;
  assign out_flags_o     = out_flags_q;
  assign core_rst_o      = core_rst_q;
  assign core_dividend_o = dvd_q;
  assign core_divisor_o  = dvs_q;

endmodule

// File: tb/tb_fp32_div_seq_ctrl.sv
module tb_fp32_div_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_dividend = '0, in_divisor = '0;
  logic [31:0] core_dividend, core_divisor;
  logic        core_rst;
  logic [31:0] core_quotient;
  logic [5:0]  core_flag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  int checks = 0;
  int errors = 0;

  // Core stand-in: counter cleared while core_rst is low, free-running
  // otherwise; presents q_val when the counter reads 15.
  logic [31:0] q_val = 32'h4040_0000;
  logic        core_stuck = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!core_rst || core_stuck) core_flag <= 6'd0;
    else                         core_flag <= core_flag + 6'd1;
  end
  assign core_quotient = (core_flag == 6'd15) ? q_val : 32'hDEAD_BEEF;

  fp32_div_seq_ctrl dut (
    .clk_i(clk), .rst_i(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_dividend_i(in_dividend), .in_divisor_i(in_divisor),
    .core_dividend_o(core_dividend), .core_divisor_o(core_divisor),
    .core_rst_o(core_rst), .core_quotient_i(core_quotient), .core_flag_i(core_flag),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_result_o(out_result), .out_flags_o(out_flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one pair; return cycles from accept edge to out_valid (-1 on
  // timeout), number of cycles core_rst was low and the first such cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int nlow, output int firstlow);
    in_dividend = a;
    in_divisor  = b;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1; nlow = 0; firstlow = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (!core_rst) begin
        nlow++;
        if (firstlow < 0) firstlow = c;
      end
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  // Complete the output handshake with out_ready high.
  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_vld_clr"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_rdy_set"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic special(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [3:0] ef);
    int lat, nlow, fl;
    run_op(a, b, lat, nlow, fl);
    check({tag, "_lat"}, lat, 32'd1);
    check({tag, "_res"}, out_result, er);
    check({tag, "_flg"}, {28'd0, out_flags}, {28'd0, ef});
    check({tag, "_nocore"}, nlow, 32'd0);
    drain(tag);
  endtask

  initial begin
    int lat, nlow, fl;
    logic [31:0] held;

    // Reset values
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_flags", {28'd0, out_flags}, 32'd0);
    check("rst_core_rst", {31'd0, core_rst}, 32'd0);
    check("rst_core_dvd", core_dividend, 32'd0);
    check("rst_core_dvs", core_divisor, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_core_rst", {31'd0, core_rst}, 32'd1);

    // 6.0 / 2.0 normal path
    run_op(32'h40C0_0000, 32'h4000_0000, lat, nlow, fl);
    check("norm_lat", lat, 32'd18);
    check("norm_rst_cycles", nlow, 32'd1);
    check("norm_rst_first", fl, 32'd1);
    check("norm_res", out_result, 32'h4040_0000);
    check("norm_flg", {28'd0, out_flags}, 32'd0);
    check("norm_core_dvd", core_dividend, 32'h40C0_0000);
    check("norm_core_dvs", core_divisor, 32'h4000_0000);
    drain("norm");

    // Special operands
    special("divzero",   32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0100);
    special("nan",       32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000);
    special("zz",        32'h8000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000);
    special("denorm",    32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 4'b0000);
    special("ninf",      32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000);
    special("infinf",    32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 4'b1000);
    special("fin_inf",   32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 4'b0000);
    special("neg_dz",    32'hC000_0000, 32'h0000_0005, 32'hFF80_0000, 4'b0100);
    special("nzero_pos", 32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 4'b0000);

    // Overflow and underflow reported from captured exponent
    q_val = 32'h7F80_0000;
    run_op(32'h40C0_0000, 32'h4000_0000, lat, nlow, fl);
    check("ovf_lat", lat, 32'd18);
    check("ovf_res", out_result, 32'h7F80_0000);
    check("ovf_flg", {28'd0, out_flags}, 32'h2);
    drain("ovf");
    q_val = 32'h0040_0000;
    run_op(32'h40C0_0000, 32'h4000_0000, lat, nlow, fl);
    check("unf_res", out_result, 32'h0040_0000);
    check("unf_flg", {28'd0, out_flags}, 32'h1);
    drain("unf");
    q_val = 32'h4040_0000;

    // Watchdog: core flag never advances
    core_stuck = 1'b1;
    run_op(32'h40C0_0000, 32'h4000_0000, lat, nlow, fl);
    check("wd_done", {31'd0, lat > 18}, 32'd1);
    check("wd_res", out_result, 32'h7FC0_0000);
    check("wd_flg", {28'd0, out_flags}, 32'h8);
    drain("wd");
    core_stuck = 1'b0;

    // Backpressure with a second pair offered while stalled
    out_ready = 1'b0;
    run_op(32'h40C0_0000, 32'h4000_0000, lat, nlow, fl);
    check("bp_lat", lat, 32'd18);
    held = out_result;
    check("bp_res", held, 32'h4040_0000);
    in_dividend = 32'h3F80_0000;
    in_divisor  = 32'h0000_0000;
    in_valid    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_res", out_result, 32'h4040_0000);
      check("bp_hold_vld", {31'd0, out_valid}, 32'd1);
      check("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    check("bp_hold_flg", {28'd0, out_flags}, 32'd0);
    drain("bp");
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_accept", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of RUN
    in_dividend = 32'h40C0_0000;
    in_divisor  = 32'h4000_0000;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_result", out_result, 32'd0);
    check("mid_rst_core_rst", {31'd0, core_rst}, 32'd0);
    check("mid_rst_core_dvd", core_dividend, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'h40C0_0000, 32'h4000_0000, lat, nlow, fl);
    check("post_rst_lat", lat, 32'd18);
    check("post_rst_res", out_result, 32'h4040_0000);
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
